serial_subtractor_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller. It computes D = a - b over WIDTH cycles using one full-subtractor cell. The cell is a sub-module built from two half-subtractor instances plus an OR gate. The block owns operand/result shift registers, the borrow flip-flop, the bit counter and a start/done handshake. Arithmetic blocks use it wherever a full-width parallel subtractor costs too much area.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 13 +
 rtl/serial_subtractor_ctrl_cell.sv | 25 ++
 rtl/serial_subtractor_ctrl.sv | 77 +++++++
 tb/tb_serial_subtractor_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_subtractor_ctrl_pkg: shared FSM encoding and defaults for the bit-serial subtractor.
//   STATE_W       - width of the controller state register
//   state_t       - S_IDLE=00, S_SHIFT=01, S_DONE=10 (11 is illegal)
//   DEFAULT_WIDTH - default operand width
package serial_subtractor_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// full_subtractor_cell: one-bit full subtractor built from two half subtractors and an OR gate.
//   half_subtractor:      x, y       -> d = x^y, bo = ~x&y
//   full_subtractor_cell: x, y, bin  -> d = x^y^bin, bout = borrow out
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .bo(b1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bo(b2));
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: computes D = a - b one bit per cycle, LSB first, through a single full-subtractor cell.
//   clk, rst_n    - clock (rising edge) and asynchronous active-low reset
//   start         - request, accepted only in IDLE; a/b captured then
//   a, b          - minuend and subtrahend
//   busy          - high while bits are being processed
//   done          - one-cycle pulse when D/B carry a new result
//   D, B          - difference mod 2^WIDTH and final borrow (a < b), held until the next result
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
);
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CNT_W-1:0] cnt;
  logic             borrow, diff, bout;
  full_subtractor_cell u_cell (.x(sa[0]), .y(sb[0]), .bin(borrow), .d(diff), .bout(bout));
  // res is internal so D/B keep the previous result until the last bit lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      B      <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_SHIFT;
          end
        S_SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= {diff, res[WIDTH-1:1]};
          borrow <= bout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            D     <= {diff, res[WIDTH-1:1]};
            B     <= bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: scoreboard bench for the serial subtractor at WIDTH=8 (directed) and WIDTH=4 (sweep).
module tb_serial_subtractor_ctrl;
  logic       clk = 0, rst_n = 0;
  logic       start8 = 0, start4 = 0;
  logic [7:0] a8 = 0, b8 = 0, D8;
  logic [3:0] a4 = 0, b4 = 0, D4;
  logic       busy8, done8, B8, busy4, done4, B4;
  int         checks = 0, errors = 0, run8 = 0, run4 = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .D(D8), .B(B8));
  serial_subtractor_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .D(D4), .B(B4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) run8 = 0;
    else if (done8) begin
      chk("done8_expected", 32'(q8.size() != 0), 1);
      chk("busy8_cycles", run8, 8);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("D8", 32'(D8), 32'(e[8:1]));
        chk("B8", 32'(B8), 32'(e[0]));
      end
      run8 = 0;
    end else run8 = busy8 ? run8 + 1 : 0;
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst_n) run4 = 0;
    else if (done4) begin
      chk("done4_expected", 32'(q4.size() != 0), 1);
      chk("busy4_cycles", run4, 4);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("D4", 32'(D4), 32'(e[4:1]));
        chk("B4", 32'(B4), 32'(e[0]));
      end
      run4 = 0;
    end else run4 = busy4 ? run4 + 1 : 0;
  end

  task automatic wait_done(input bit w4);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(w4 ? done4 : done8) && n < 40);
    chk(w4 ? "done4_seen" : "done8_seen", 32'(w4 ? done4 : done8), 1);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d, input logic bo);
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1;
    q8.push_back({d, bo});
    @(negedge clk);
    start8 = 0;
    wait_done(0);
  endtask

  initial begin
    int n;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_D", 32'(D8), 0);
    chk("rst_B", 32'(B8), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy8), 0);

    op8(8'h25, 8'h13, 8'h12, 0);
    op8(8'h13, 8'h25, 8'hEE, 1);
    op8(8'h00, 8'h01, 8'hFF, 1);

    // back-to-back with start held high; operands swapped mid-SHIFT
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1;
    q8.push_back({8'h00, 1'b0});
    q8.push_back({8'h01, 1'b0});
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h7F;
    wait_done(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy8 && n < 10);
    chk("b2b_gap", n, 2);
    start8 = 0;
    wait_done(0);

    // ignored starts mid-SHIFT and in DONE; D/B hold previous result during SHIFT
    @(negedge clk);
    a8 = 8'h25; b8 = 8'h13; start8 = 1;
    q8.push_back({8'h12, 1'b0});
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      start8 = (i == 3);
      if (i == 3) begin a8 = 8'h00; b8 = 8'hFF; end
      if (busy8) begin
        chk("hold_D", 32'(D8), 32'h01);
        chk("hold_B", 32'(B8), 0);
      end
      seen = done8;
    end
    chk("ign_done_seen", 32'(seen), 1);
    start8 = 1; a8 = 8'h00; b8 = 8'hFF;
    @(negedge clk);
    start8 = 0;
    repeat (12) @(negedge clk);
    chk("ign_q_empty", q8.size(), 0);
    chk("ign_D", 32'(D8), 32'h12);

    // reset mid-SHIFT aborts without a done pulse
    @(negedge clk);
    a8 = 8'h13; b8 = 8'h25; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy8), 1);
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_D", 32'(D8), 0);
    chk("abort_B", 32'(B8), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (15) @(negedge clk);
    chk("post_abort_busy", 32'(busy8), 0);
    chk("post_abort_D", 32'(D8), 0);

    // exhaustive WIDTH=4 sweep
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        a4 = 4'(x); b4 = 4'(y); start4 = 1;
        q4.push_back({4'(x - y), 1'(x < y)});
        @(negedge clk);
        start4 = 0;
        wait_done(1);
      end
    repeat (5) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
